spi_slave_word: RTL and testbench

// Parametrised SPI slave running entirely in the i_sys_clk domain: SCK, CS_b and MOSI are oversampled

---
 rtl/spi_slave_word.sv | 136 +++++++++++++
 tb/tb_spi_slave_word.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_word.sv
// spi_slave_word: SPI slave oversampled in the system clock domain, with word framing,
// all four CPOL/CPHA modes and a one-word TX holding register with ready/valid handshake.
module spi_slave_word #(
    parameter int                DATA_W      = 8,
    parameter bit                CPOL        = 1'b0,
    parameter bit                CPHA        = 1'b0,
    parameter bit                MSB_FIRST   = 1'b1,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] FILL_WORD   = '0
) (
    input  logic              i_sys_clk,
    input  logic              i_rst_b,
    input  logic              i_spi_sck,
    input  logic              i_spi_cs_b,
    input  logic              i_spi_mosi,
    output logic              o_spi_miso,
    output logic              o_spi_miso_oe,
    output logic              o_rx_data_valid,
    output logic [DATA_W-1:0] o_rx_data,
    input  logic              i_tx_data_valid,
    input  logic [DATA_W-1:0] i_tx_data,
    output logic              o_tx_ready,
    output logic              o_tx_underrun,
    output logic              o_frame_start,
    output logic              o_frame_end
);
    localparam int CW = $clog2(DATA_W);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sck_prev_q, cs_prev_q;
    logic [CW-1:0]          cnt_q;
    logic [DATA_W-1:0]      rx_sr_q, tx_sr_q, hold_q;
    logic                   hold_full_q, word_done_q;
    logic                   sck_s, cs_s, mosi_s;
    logic                   lead, trail, sample_e, shift_e, cs_fall, cs_rise;
    logic                   last_bit, load, take, bypass;
    logic [DATA_W-1:0]      rx_d, load_d;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w << 1 : w >> 1;
    endfunction

    assign sck_s      = sck_sync_q[SYNC_STAGES-1];
    assign cs_s       = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign o_tx_ready = !hold_full_q;

    always_comb begin
        lead     = (sck_s != CPOL) && (sck_prev_q == CPOL);
        trail    = (sck_s == CPOL) && (sck_prev_q != CPOL);
        sample_e = (state_q == ACTIVE) && (CPHA ? trail : lead);
        shift_e  = (state_q == ACTIVE) && (CPHA ? lead : trail);
        cs_fall  = (state_q == IDLE) && cs_prev_q && !cs_s;
        cs_rise  = (state_q == ACTIVE) && !cs_prev_q && cs_s;
        last_bit = cnt_q == CW'(DATA_W - 1);
        // A new word is fetched at frame start, and on the first shift edge after a completed word.
        load     = cs_fall || (shift_e && word_done_q && !cs_rise);
        take     = i_tx_data_valid && !hold_full_q;
        bypass   = take && load;
        load_d   = bypass ? i_tx_data : hold_full_q ? hold_q : FILL_WORD;
        rx_d     = MSB_FIRST ? {rx_sr_q[DATA_W-2:0], mosi_s} : {mosi_s, rx_sr_q[DATA_W-1:1]};
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state_q         <= IDLE;
            sck_sync_q      <= {SYNC_STAGES{CPOL}};
            cs_sync_q       <= '1;
            mosi_sync_q     <= '0;
            sck_prev_q      <= CPOL;
            cs_prev_q       <= 1'b1;
            cnt_q           <= '0;
            rx_sr_q         <= '0;
            tx_sr_q         <= '0;
            hold_q          <= '0;
            hold_full_q     <= 1'b0;
            word_done_q     <= 1'b0;
            o_spi_miso      <= first_bit(FILL_WORD);
            o_spi_miso_oe   <= 1'b0;
            o_rx_data_valid <= 1'b0;
            o_rx_data       <= '0;
            o_tx_underrun   <= 1'b0;
            o_frame_start   <= 1'b0;
            o_frame_end     <= 1'b0;
        end else begin
            sck_sync_q      <= {sck_sync_q[SYNC_STAGES-2:0], i_spi_sck};
            cs_sync_q       <= {cs_sync_q[SYNC_STAGES-2:0], i_spi_cs_b};
            mosi_sync_q     <= {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
            sck_prev_q      <= sck_s;
            cs_prev_q       <= cs_s;
            o_rx_data_valid <= 1'b0;
            o_tx_underrun   <= load && !bypass && !hold_full_q;
            o_frame_start   <= cs_fall;
            o_frame_end     <= cs_rise;
            if (take && !load) begin
                hold_q      <= i_tx_data;
                hold_full_q <= 1'b1;
            end else if (load) begin
                hold_full_q <= 1'b0;
            end
            if (sample_e) begin
                rx_sr_q <= rx_d;
                cnt_q   <= last_bit ? '0 : cnt_q + CW'(1);
                if (last_bit) begin
                    o_rx_data       <= rx_d;
                    o_rx_data_valid <= 1'b1;
                    word_done_q     <= 1'b1;
                end
            end
            // With CPHA=1 the first bit of a frame waits for the first shift edge.
            if (load) begin
                tx_sr_q     <= (CPHA && cs_fall) ? load_d : advance(load_d);
                o_spi_miso  <= (CPHA && cs_fall) ? o_spi_miso : first_bit(load_d);
                word_done_q <= 1'b0;
            end else if (shift_e) begin
                tx_sr_q    <= advance(tx_sr_q);
                o_spi_miso <= first_bit(tx_sr_q);
            end
            if (state_q == IDLE && cs_fall) begin
                state_q       <= ACTIVE;
                o_spi_miso_oe <= 1'b1;
                cnt_q         <= '0;
            end else if (state_q == ACTIVE && cs_rise) begin
                state_q       <= IDLE;
                o_spi_miso_oe <= 1'b0;
                cnt_q         <= '0;
                word_done_q   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_word.sv
// tb_spi_slave_word: directed bench over five slave instances (modes 0..3 at 8 bits, mode 0 16-bit LSB-first).
module tb_spi_slave_word;
    logic        clk = 1'b0, rst_b = 1'b0, mosi = 1'b0;
    logic [4:0]  sck = 5'b01100, cs_b = 5'h1f, txv = '0;
    logic [15:0] txd [5];
    logic [15:0] rxd [5];
    logic [4:0]  miso, oe, rxv, rdy, und, fs, fe;
    int          rxv_n [5], und_n [5], fs_n [5], fe_n [5];
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int DW = (g == 4) ? 16 : 8;
        logic [DW-1:0] rd;
        spi_slave_word #(
            .DATA_W(DW), .CPOL(g == 2 || g == 3), .CPHA(g == 1 || g == 3), .MSB_FIRST(g != 4),
            .SYNC_STAGES(2), .FILL_WORD(DW'(g == 4 ? 16'hBEEF : 16'h00C6))
        ) u_dut (
            .i_sys_clk(clk), .i_rst_b(rst_b), .i_spi_sck(sck[g]), .i_spi_cs_b(cs_b[g]),
            .i_spi_mosi(mosi), .o_spi_miso(miso[g]), .o_spi_miso_oe(oe[g]),
            .o_rx_data_valid(rxv[g]), .o_rx_data(rd), .i_tx_data_valid(txv[g]),
            .i_tx_data(txd[g][DW-1:0]), .o_tx_ready(rdy[g]), .o_tx_underrun(und[g]),
            .o_frame_start(fs[g]), .o_frame_end(fe[g])
        );
        assign rxd[g] = 16'(rd);
    end

    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            rxv_n[i] += int'(rxv[i]);
            und_n[i] += int'(und[i]);
            fs_n[i]  += int'(fs[i]);
            fe_n[i]  += int'(fe[i]);
        end
    end

    task automatic half;
        repeat (5) @(negedge clk);
    endtask

    task automatic preload(input int k, input logic [15:0] d);
        @(negedge clk);
        txd[k] = d;
        txv[k] = 1'b1;
        @(negedge clk);
        txv[k] = 1'b0;
    endtask

    task automatic cs_low(input int k);
        @(negedge clk);
        cs_b[k] = 1'b0;
        half();
    endtask

    task automatic cs_high(input int k);
        @(negedge clk);
        cs_b[k] = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Host side of one word; optionally offers a TX word exactly when the slave fetches its next word.
    task automatic xfer(input int k, input logic [15:0] mo, input int nbits, input bit byp,
                        input logic [15:0] bd, output logic [15:0] mi);
        bit cpol, cpha, msb;
        int dw, idx;
        cpol = (k == 2 || k == 3);
        cpha = (k == 1 || k == 3);
        msb  = (k != 4);
        dw   = (k == 4) ? 16 : 8;
        mi   = '0;
        for (int i = 0; i < nbits; i++) begin
            idx = msb ? dw - 1 - i : i;
            if (!cpha) begin
                mosi = mo[idx];
                half();
                mi[idx] = miso[k];
                sck[k] = !cpol;
                half();
                sck[k] = cpol;
            end else begin
                half();
                sck[k] = !cpol;
                mosi = mo[idx];
                half();
                mi[idx] = miso[k];
                sck[k] = cpol;
            end
        end
        if (byp) begin
            repeat (2) @(negedge clk);
            txd[k] = bd;
            txv[k] = 1'b1;
            @(negedge clk);
            txv[k] = 1'b0;
        end
        half();
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (oe !== 5'h00) begin failures++; $display("FAIL reset_oe got=%b exp=%b", oe, 5'h00); end
        checks++; if (rdy !== 5'h1f) begin failures++; $display("FAIL reset_ready got=%b exp=%b", rdy, 5'h1f); end
        checks++; if (miso !== 5'h1f) begin failures++; $display("FAIL reset_miso got=%b exp=%b", miso, 5'h1f); end
        checks++; if ((rxv | und | fs | fe) !== 5'h00) begin failures++; $display("FAIL reset_pulses got=%b exp=%b", rxv | und | fs | fe, 5'h00); end
        checks++; if (rxd[0] !== 16'h0) begin failures++; $display("FAIL reset_rx0 got=%h exp=%h", rxd[0], 16'h0); end
        checks++; if (rxd[4] !== 16'h0) begin failures++; $display("FAIL reset_rx4 got=%h exp=%h", rxd[4], 16'h0); end
    endtask

    task automatic test_mode0;
        logic [15:0] mi;
        int r0, f0, e0;
        preload(0, 16'hA5);
        checks++; if (rdy[0] !== 1'b0) begin failures++; $display("FAIL m0_ready_drop got=%b exp=0", rdy[0]); end
        r0 = rxv_n[0]; f0 = fs_n[0]; e0 = fe_n[0];
        cs_low(0);
        checks++; if (fs_n[0] - f0 !== 1) begin failures++; $display("FAIL m0_frame_start got=%0d exp=1", fs_n[0] - f0); end
        checks++; if (oe[0] !== 1'b1) begin failures++; $display("FAIL m0_oe_active got=%b exp=1", oe[0]); end
        xfer(0, 16'h3C, 8, 1'b0, 16'h0, mi);
        checks++; if (mi !== 16'hA5) begin failures++; $display("FAIL m0_miso got=%h exp=%h", mi, 16'hA5); end
        checks++; if (rxd[0] !== 16'h3C) begin failures++; $display("FAIL m0_rx got=%h exp=%h", rxd[0], 16'h3C); end
        checks++; if (rxv_n[0] - r0 !== 1) begin failures++; $display("FAIL m0_rx_pulses got=%0d exp=1", rxv_n[0] - r0); end
        cs_high(0);
        checks++; if (fe_n[0] - e0 !== 1) begin failures++; $display("FAIL m0_frame_end got=%0d exp=1", fe_n[0] - e0); end
        checks++; if (oe[0] !== 1'b0) begin failures++; $display("FAIL m0_oe_idle got=%b exp=0", oe[0]); end
        checks++; if (rdy[0] !== 1'b1) begin failures++; $display("FAIL m0_ready_back got=%b exp=1", rdy[0]); end
    endtask

    task automatic test_modes;
        logic [15:0] mi;
        int r0;
        for (int k = 1; k < 4; k++) begin
            preload(k, 16'h81);
            r0 = rxv_n[k];
            cs_low(k);
            xfer(k, 16'h81, 8, 1'b0, 16'h0, mi);
            cs_high(k);
            checks++; if (mi !== 16'h81) begin failures++; $display("FAIL mode%0d_miso got=%h exp=%h", k, mi, 16'h81); end
            checks++; if (rxd[k] !== 16'h81) begin failures++; $display("FAIL mode%0d_rx got=%h exp=%h", k, rxd[k], 16'h81); end
            checks++; if (rxv_n[k] - r0 !== 1) begin failures++; $display("FAIL mode%0d_rx_pulses got=%0d exp=1", k, rxv_n[k] - r0); end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] mi;
        logic [15:0] mo [3], exp_mi [3];
        int r0, u0;
        mo = '{16'h11, 16'h22, 16'h33};
        exp_mi = '{16'h5A, 16'hC6, 16'hC6};
        preload(1, 16'h5A);
        r0 = rxv_n[1]; u0 = und_n[1];
        cs_low(1);
        for (int w = 0; w < 3; w++) begin
            xfer(1, mo[w], 8, 1'b0, 16'h0, mi);
            checks++; if (mi !== exp_mi[w]) begin failures++; $display("FAIL b2b_miso%0d got=%h exp=%h", w, mi, exp_mi[w]); end
            checks++; if (rxd[1] !== mo[w]) begin failures++; $display("FAIL b2b_rx%0d got=%h exp=%h", w, rxd[1], mo[w]); end
        end
        cs_high(1);
        checks++; if (und_n[1] - u0 !== 2) begin failures++; $display("FAIL b2b_underruns got=%0d exp=2", und_n[1] - u0); end
        checks++; if (rxv_n[1] - r0 !== 3) begin failures++; $display("FAIL b2b_rx_pulses got=%0d exp=3", rxv_n[1] - r0); end
    endtask

    task automatic test_abort;
        logic [15:0] mi;
        int r0, e0;
        r0 = rxv_n[0]; e0 = fe_n[0];
        cs_low(0);
        xfer(0, 16'hFF, 5, 1'b0, 16'h0, mi);
        cs_high(0);
        checks++; if (rxv_n[0] - r0 !== 0) begin failures++; $display("FAIL abort_rx_pulses got=%0d exp=0", rxv_n[0] - r0); end
        checks++; if (fe_n[0] - e0 !== 1) begin failures++; $display("FAIL abort_frame_end got=%0d exp=1", fe_n[0] - e0); end
        checks++; if (rxd[0] !== 16'h3C) begin failures++; $display("FAIL abort_rx_held got=%h exp=%h", rxd[0], 16'h3C); end
        r0 = rxv_n[0];
        cs_low(0);
        xfer(0, 16'hC3, 8, 1'b0, 16'h0, mi);
        cs_high(0);
        checks++; if (rxd[0] !== 16'hC3) begin failures++; $display("FAIL abort_next_rx got=%h exp=%h", rxd[0], 16'hC3); end
        checks++; if (rxv_n[0] - r0 !== 1) begin failures++; $display("FAIL abort_next_pulses got=%0d exp=1", rxv_n[0] - r0); end
        checks++; if (mi !== 16'hC6) begin failures++; $display("FAIL abort_next_fill got=%h exp=%h", mi, 16'hC6); end
    endtask

    task automatic test_lsb16;
        logic [15:0] mi;
        int r0, u0;
        preload(4, 16'hA1B2);
        r0 = rxv_n[4]; u0 = und_n[4];
        cs_low(4);
        xfer(4, 16'h1234, 16, 1'b1, 16'h5678, mi);
        checks++; if (mi !== 16'hA1B2) begin failures++; $display("FAIL lsb_miso0 got=%h exp=%h", mi, 16'hA1B2); end
        checks++; if (rxd[4] !== 16'h1234) begin failures++; $display("FAIL lsb_rx0 got=%h exp=%h", rxd[4], 16'h1234); end
        xfer(4, 16'hF00D, 16, 1'b1, 16'h9ABC, mi);
        checks++; if (mi !== 16'h5678) begin failures++; $display("FAIL lsb_bypass_miso got=%h exp=%h", mi, 16'h5678); end
        checks++; if (rxd[4] !== 16'hF00D) begin failures++; $display("FAIL lsb_rx1 got=%h exp=%h", rxd[4], 16'hF00D); end
        cs_high(4);
        checks++; if (und_n[4] - u0 !== 0) begin failures++; $display("FAIL lsb_underruns got=%0d exp=0", und_n[4] - u0); end
        checks++; if (rxv_n[4] - r0 !== 2) begin failures++; $display("FAIL lsb_rx_pulses got=%0d exp=2", rxv_n[4] - r0); end
        checks++; if (rdy[4] !== 1'b1) begin failures++; $display("FAIL lsb_ready got=%b exp=1", rdy[4]); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] mi;
        preload(0, 16'h77);
        cs_low(0);
        xfer(0, 16'h0F, 4, 1'b0, 16'h0, mi);
        preload(0, 16'h55);
        checks++; if (rdy[0] !== 1'b0) begin failures++; $display("FAIL rst_mid_full got=%b exp=0", rdy[0]); end
        rst_b = 1'b0;
        #1;
        checks++; if (oe[0] !== 1'b0) begin failures++; $display("FAIL rst_mid_oe got=%b exp=0", oe[0]); end
        checks++; if (rdy[0] !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", rdy[0]); end
        checks++; if (miso[0] !== 1'b1) begin failures++; $display("FAIL rst_mid_miso got=%b exp=1", miso[0]); end
        checks++; if (rxd[0] !== 16'h0) begin failures++; $display("FAIL rst_mid_rx got=%h exp=%h", rxd[0], 16'h0); end
        cs_b[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        preload(0, 16'hA5);
        cs_low(0);
        xfer(0, 16'h3C, 8, 1'b0, 16'h0, mi);
        cs_high(0);
        checks++; if (mi !== 16'hA5) begin failures++; $display("FAIL rst_after_miso got=%h exp=%h", mi, 16'hA5); end
        checks++; if (rxd[0] !== 16'h3C) begin failures++; $display("FAIL rst_after_rx got=%h exp=%h", rxd[0], 16'h3C); end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) txd[i] = '0;
        test_reset();
        test_mode0();
        test_modes();
        test_back_to_back();
        test_abort();
        test_lsb16();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
